// File: rtl/dbus_poll_master.sv
// Purpose : periodically reads SRC_ADDR over a DATA_BUS initiator port and writes the value to DST_ADDR when it changes.
// Latency : a poll starts POLL_CYCLES idle cycles after the last one; one transaction outstanding, min poll period POLL_CYCLES+2.
// Backpres: request outputs are held stable until gnt; wait states stall on rvalid (bounded by RSP_TIMEOUT when enabled).
//
// Ports:
//   clk, rst            single rising-edge clock, asynchronous active-high reset
//   enable              polling permitted while high (an in-flight transaction always completes)
//   dmst_req/addr/we/be/wdata   bus request outputs; idle values are 0 with be=4'hF
//   dmst_gnt/rvalid/rdata       bus grant and response inputs
//   last_val            most recent value read from SRC_ADDR
//   xfer_cnt            completed DST_ADDR writes, wraps at 16 bits
//   busy                high whenever the FSM is not IDLE
//   err                 sticky response timeout flag
//
// Optional feature: define DBUS_POLL_TIMEOUT_EN to build the response timeout
// counter; without it the wait states wait forever and err is tied low.

module dbus_poll_master #(
    parameter int unsigned POLL_CYCLES = 1000,
    parameter logic [31:0] SRC_ADDR    = 32'h0000_0000,
    parameter logic [31:0] DST_ADDR    = 32'h0000_0004,
    parameter int unsigned RSP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        dmst_req,
    output logic [31:0] dmst_addr,
    output logic        dmst_we,
    output logic [3:0]  dmst_be,
    output logic [31:0] dmst_wdata,
    input  logic        dmst_gnt,
    input  logic        dmst_rvalid,
    input  logic [31:0] dmst_rdata,
    output logic [31:0] last_val,
    output logic [15:0] xfer_cnt,
    output logic        busy,
    output logic        err
);

    localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(POLL_CYCLES - 1);

    // Elaboration-time sanity check on the parameters.
    if ((POLL_CYCLES < 1) || (RSP_TIMEOUT < 1)) begin : g_param_check
        $error("dbus_poll_master: POLL_CYCLES and RSP_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            first;
    logic            in_wait;
    logic            timeout;

    assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef DBUS_POLL_TIMEOUT_EN
    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    // Counts wait-state cycles without rvalid; cleared in every other state
    // so each transaction gets a fresh budget of RSP_TIMEOUT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (in_wait && !dmst_rvalid) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    assign timeout = in_wait && !dmst_rvalid && (tcnt == TW'(RSP_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dmst_req   = 1'b0;
        dmst_we    = 1'b0;
        dmst_addr  = 32'h0;
        dmst_wdata = 32'h0;
        dmst_be    = 4'hF;
        case (state)
            IDLE: begin
                if (enable && (cnt == '0)) begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                dmst_req  = 1'b1;
                dmst_addr = SRC_ADDR;
                if (dmst_gnt) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // The first poll after reset always writes, even if the value
                // happens to match the reset value of last_val.
                if (dmst_rvalid) begin
                    state_nxt = (first || (dmst_rdata != last_val)) ? WR_REQ : IDLE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                dmst_req   = 1'b1;
                dmst_we    = 1'b1;
                dmst_addr  = DST_ADDR;
                dmst_wdata = last_val;
                if (dmst_gnt) begin
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (dmst_rvalid || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Interval counter: reloaded while a poll is in flight, so after the
    // transaction it restarts a full POLL_CYCLES interval; frozen while
    // enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (state != IDLE) begin
            cnt <= RELOAD;
        end else if (enable) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val <= 32'h0;
            first    <= 1'b1;
            xfer_cnt <= 16'h0;
        end else begin
            if ((state == RD_WAIT) && dmst_rvalid) begin
                last_val <= dmst_rdata;
                first    <= 1'b0;
            end
            if ((state == WR_WAIT) && dmst_rvalid) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/dbus_poll_master.md
DBUS_POLL_MASTER -- requirements
Module: dbus_poll_master

Interface
REQ-001 Parameter POLL_CYCLES, default 1000: idle cycles between poll starts, minimum 1.
REQ-002 Parameter SRC_ADDR, default 32'h0000_0000: byte address read each poll.
REQ-003 Parameter DST_ADDR, default 32'h0000_0004: byte address written when the read value changes.
REQ-004 Parameter RSP_TIMEOUT, default 64: maximum cycles from grant to rvalid before an error is declared.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  polling permitted while high.
REQ-008 dmst  DATA_BUS  -  initiator end; drives req, addr[31:0], we, be[3:0], wdata[31:0]; samples gnt, rvalid, rdata[31:0].
REQ-009 last_val  output  32  most recent rdata captured from SRC_ADDR.
REQ-010 xfer_cnt  output  16  count of completed DST_ADDR writes, wraps at 16'hFFFF to 0.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  sticky response-timeout flag.

Function
REQ-013 States SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ and WR_WAIT, with one transaction outstanding at most.
REQ-014 In IDLE, a down-counter SHALL load POLL_CYCLES-1 and decrement while enable is high; at 0 it SHALL go to RD_REQ, and if enable is low it SHALL hold its value.
REQ-015 RD_REQ SHALL drive req=1, we=0, be=4'hF, addr=SRC_ADDR, wdata=0, and hold them stable until gnt is sampled high.
REQ-016 On gnt in RD_REQ, req SHALL deassert the next cycle and the state SHALL become RD_WAIT.
REQ-017 In RD_WAIT, on rvalid, rdata SHALL be captured into last_val; if it differs from the previous last_val, or this is the first poll after reset, the state SHALL go to WR_REQ, otherwise to IDLE.
REQ-018 WR_REQ SHALL drive req=1, we=1, be=4'hF, addr=DST_ADDR, wdata=last_val, and hold them stable until gnt.
REQ-019 WR_WAIT SHALL go to IDLE on rvalid and increment xfer_cnt in that same cycle.
REQ-020 When idle, the bus outputs SHALL be driven to 0 (req, we, addr, wdata) and be to 4'hF.
REQ-021 rvalid sampled outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-022 gnt and rvalid high in the same cycle as the request SHALL complete only the request phase; the response SHALL be expected from the next cycle onward.
REQ-023 enable falling mid-transaction SHALL NOT abort it; the FSM SHALL return to IDLE and then hold.
REQ-024 Minimum poll period SHALL be POLL_CYCLES + 2 cycles with zero-wait gnt and a 1-cycle rvalid.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, req=0, we=0, addr=0, wdata=0, be=4'hF, last_val=0, xfer_cnt=0, busy=0, err=0, counter=POLL_CYCLES-1, and set the first-poll flag.
REQ-026 Reset asserted mid-transaction SHALL abandon it; a late rvalid after release SHALL be ignored per REQ-021.

Configuration
REQ-027 With macro DBUS_POLL_TIMEOUT_EN defined, a response counter SHALL run in RD_WAIT/WR_WAIT, and on reaching RSP_TIMEOUT with no rvalid it SHALL set err, return to IDLE, and leave last_val and xfer_cnt unchanged.
REQ-028 Without DBUS_POLL_TIMEOUT_EN, the wait states SHALL wait indefinitely, err SHALL be tied to 0, and no timeout counter SHALL be synthesized.
REQ-029 err SHALL clear only on rst.

Verification
REQ-030 POLL_CYCLES=4, enable=1, zero-wait slave returning rdata=32'h0000_FFFF -> read at SRC_ADDR, then write of 32'h0000_FFFF to DST_ADDR, xfer_cnt=1.
REQ-031 Second poll returns the same 32'h0000_FFFF -> read only, no write, xfer_cnt stays 1; third poll returns 32'h15 -> write of 32'h15, xfer_cnt=2.
REQ-032 gnt delayed 3 cycles -> req/addr/we stable for all 4 cycles, req low the cycle after gnt.
REQ-033 enable dropped during RD_WAIT -> read completes, FSM returns to IDLE and holds, no new req while enable is low.
REQ-034 With DBUS_POLL_TIMEOUT_EN and RSP_TIMEOUT=8, rvalid withheld -> err=1 after 8 cycles, busy=0, xfer_cnt unchanged; without the macro, busy stays 1.
REQ-035 rst pulsed in WR_REQ -> all outputs at reset values asynchronously; first poll after release always writes.
